fpu_div_seq: RTL and testbench
==============================

Name: fpu_div_seq

Overview:
- Divide/remainder sequencer for the FPU increment datapath.
- On a start request it steps the 4-bit incfunc code through divide iterations, with quotient bits accumulated in the datapath Q registers, then issues an optional quotient transfer and a completion pulse.
- Drives both the registered incfunc code and the one-cycle-early nx_incfunc code that feeds the datapath mode decode ROMs.
- Sits between the FPU microsequencer (start/abort) and the increment datapath.

Parameters:
- SP_ITERS, 26, divide-step cycles for single precision.
- DP_ITERS, 55, divide-step cycles for double precision.
- CNT_W, 6, iteration counter width; must hold DP_ITERS-1.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset_l  input  1  asynchronous, active-low reset.
- fpuhold  input  1  global stall; when 1, all state, counter and output registers hold.
- start  input  1  request to begin an operation; level, sampled only in IDLE with fpuhold=0.
- dprec  input  1  1=double precision; sampled with start.
- rem_op  input  1  1=remainder (skip quotient transfer); sampled with start.
- div0  input  1  divisor is zero; sampled with start.
- abort  input  1  cancel the operation; return to IDLE.
- nx_incfunc  output  4  next-cycle function code (combinational from next state).
- incfunc  output  4  registered function code driving the datapath.
- busy  output  1  1 in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- dz  output  1  divide-by-zero flag; valid while done=1.
- iter_cnt  output  CNT_W  remaining divide steps.

Behaviour:
- Reset (async, reset_l=0):
  - state=IDLE, incfunc=4'h0, iter_cnt=0, done=0, dz=0, busy=0.
  - Latched dprec and rem_op are cleared.
- Function codes per state, registered as incfunc:
  - IDLE=4'h0 (Q registers clear).
  - ITER=4'h8 (divide step: quotient bit shifted into Q).
  - QOUT=4'h9 (Q transferred to the A outputs).
  - DONE=4'hb (Q held).
- Code timing:
  - nx_incfunc = code of next_state.
  - incfunc <= nx_incfunc whenever fpuhold=0.
  - incfunc therefore always equals the code of the current state.
- States and transitions (all evaluated only when fpuhold=0):
  - IDLE:
    - start=1, div0=1 -> DONE, dz set.
    - start=1, div0=0 -> ITER, iter_cnt loaded with (dprec ? DP_ITERS : SP_ITERS)-1, dprec/rem_op latched.
  - ITER:
    - iter_cnt!=0 -> stay, iter_cnt decrements.
    - iter_cnt==0 -> QOUT if rem_op=0, else DONE.
    - Exactly SP_ITERS or DP_ITERS cycles spent in ITER.
  - QOUT: one cycle -> DONE.
  - DONE:
    - done=1 for this cycle only -> IDLE.
    - dz clears on leaving DONE.
- busy = (state!=IDLE), registered with state.
- fpuhold=1:
  - state, iter_cnt, incfunc, latched mode bits and dz frozen.
  - done is a decode of state, so it stays high if hold arrives in DONE; the consumer qualifies done with !fpuhold.
  - nx_incfunc reflects the frozen state's code.
- abort=1:
  - From any non-IDLE state -> IDLE next edge, iter_cnt=0, no done pulse, dz=0.
  - abort overrides fpuhold.
  - abort in IDLE has no effect; abort overrides a same-cycle start.
- start while busy is ignored; no queuing.
- start with fpuhold=1 in IDLE is not accepted; the requester holds start.
- Counter never wraps: decrement only when iter_cnt!=0.
- No X on any output after reset; unused incfunc codes are never produced.

Test Plan:
- Single divide: reset, start=1, dprec=0, rem_op=0, div0=0 for one cycle -> incfunc=8 for exactly 26 cycles, then 9 for 1 cycle, then b with done=1 for 1 cycle, then 0. busy high 28 cycles.
- Double remainder: start with dprec=1, rem_op=1 -> 55 cycles of incfunc=8, no 4'h9 cycle, done on the 56th busy cycle. nx_incfunc leads incfunc by exactly one cycle throughout.
- Divide by zero: start with div0=1 -> next cycle DONE, done=1, dz=1, incfunc=b. dz=0 the following cycle. No incfunc=8 cycle.
- Stall: fpuhold=1 for 5 cycles at iter_cnt=10 -> iter_cnt, incfunc and state frozen. Total ITER cycles still 26; done delayed by exactly 5.
- Abort: abort at iter_cnt=3, with fpuhold=1 in the same cycle -> next edge IDLE, incfunc=0, busy=0, no done pulse. A new start is accepted the cycle after.
- Async reset mid-ITER: drop reset_l between clock edges -> outputs go to reset values immediately without waiting for clk. Start after release behaves as in the first scenario.

Source files
------------

// File: rtl/fpu_div_seq.sv
// fpu_div_seq: divide/remainder sequencer stepping the increment datapath incfunc code.
// nx_incfunc is the code of the next state, so incfunc always equals the current state's code.
module fpu_div_seq #(
   parameter int SP_ITERS = 26,
   parameter int DP_ITERS = 55,
   parameter int CNT_W    = 6
) (
   input  logic             clk,
   input  logic             reset_l,
   input  logic             fpuhold,
   input  logic             start,
   input  logic             dprec,
   input  logic             rem_op,
   input  logic             div0,
   input  logic             abort,
   output logic [3:0]       nx_incfunc,
   output logic [3:0]       incfunc,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [CNT_W-1:0] iter_cnt
);
   typedef enum logic [1:0] {S_IDLE, S_ITER, S_QOUT, S_DONE} state_t;
   localparam logic [CNT_W-1:0] SP_LOAD = CNT_W'(SP_ITERS - 1);
   localparam logic [CNT_W-1:0] DP_LOAD = CNT_W'(DP_ITERS - 1);
   state_t           r_state, w_step, w_next;
   logic [3:0]       r_incfunc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_dz, r_rem, w_abort, w_start;
   assign w_abort = abort && (r_state != S_IDLE);
   assign w_start = start && !abort;
   always_comb begin
      w_step = r_state;
      case (r_state)
         S_IDLE:  w_step = w_start ? (div0 ? S_DONE : S_ITER) : S_IDLE;
         S_ITER:  w_step = (r_cnt != '0) ? S_ITER : (r_rem ? S_DONE : S_QOUT);
         S_QOUT:  w_step = S_DONE;
         default: w_step = S_IDLE;
      endcase
   end
   // abort wins over a stall; a stall freezes the next state to the current one
   assign w_next     = w_abort ? S_IDLE : (fpuhold ? r_state : w_step);
   assign nx_incfunc = (w_next == S_ITER) ? 4'h8 :
                       (w_next == S_QOUT) ? 4'h9 :
                       (w_next == S_DONE) ? 4'hb : 4'h0;
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         r_state   <= S_IDLE;
         r_incfunc <= 4'h0;
         r_cnt     <= '0;
         r_dz      <= 1'b0;
         r_rem     <= 1'b0;
      end else if (w_abort) begin
         r_state   <= S_IDLE;
         r_incfunc <= 4'h0;
         r_cnt     <= '0;
         r_dz      <= 1'b0;
         r_rem     <= 1'b0;
      end else if (!fpuhold) begin
         r_state   <= w_next;
         r_incfunc <= nx_incfunc;
         if (r_state == S_IDLE && w_start) begin
            r_dz <= div0;
            if (!div0) begin
               r_cnt <= dprec ? DP_LOAD : SP_LOAD;
               r_rem <= rem_op;
            end
         end else if (r_state == S_ITER && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end else if (r_state == S_DONE) begin
            r_dz <= 1'b0;
         end
      end
   end
   assign incfunc  = r_incfunc;
   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_DONE);
   assign dz       = r_dz;
   assign iter_cnt = r_cnt;
endmodule

// File: tb/tb_fpu_div_seq.sv
// tb_fpu_div_seq: directed checks of fpu_div_seq sequencing, stall, abort and reset.
module tb_fpu_div_seq;
   logic       clk, reset_l, fpuhold, start, dprec, rem_op, div0, abort;
   logic [3:0] nx_incfunc, incfunc;
   logic       busy, done, dz;
   logic [5:0] iter_cnt;
   int checks, errors;
   int n8, n9, nb, nbusy, ndone, ndz, lead_err;
   logic [3:0] nx_prev;

   fpu_div_seq dut (
      .clk(clk), .reset_l(reset_l), .fpuhold(fpuhold), .start(start), .dprec(dprec),
      .rem_op(rem_op), .div0(div0), .abort(abort), .nx_incfunc(nx_incfunc),
      .incfunc(incfunc), .busy(busy), .done(done), .dz(dz), .iter_cnt(iter_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      n8 = 0; n9 = 0; nb = 0; nbusy = 0; ndone = 0; ndz = 0; lead_err = 0;
   endtask

   // one clock; nx_incfunc sampled mid-cycle must reappear as incfunc after the edge
   task automatic step();
      @(negedge clk);
      nx_prev = nx_incfunc;
      @(posedge clk);
      #1;
      if (incfunc !== nx_prev) lead_err++;
      n8    += (incfunc == 4'h8) ? 1 : 0;
      n9    += (incfunc == 4'h9) ? 1 : 0;
      nb    += (incfunc == 4'hb) ? 1 : 0;
      nbusy += busy ? 1 : 0;
      ndone += done ? 1 : 0;
      ndz   += dz ? 1 : 0;
   endtask

   task automatic run_to_idle(input string tag);
      int k;
      k = 0;
      while (busy && k < 200) begin
         step();
         k++;
      end
      check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic go(input logic dp, input logic rem, input logic z);
      dprec = dp; rem_op = rem; div0 = z; start = 1'b1;
      step();
      start = 1'b0; dprec = 1'b0; rem_op = 1'b0; div0 = 1'b0;
   endtask

   task automatic wait_cnt(input string tag, input int v);
      int k;
      k = 0;
      while (iter_cnt != 6'(v) && k < 100) begin
         step();
         k++;
      end
      check({tag, "_cnt_reach"}, {26'd0, iter_cnt}, v);
   endtask

   task automatic single_divide(input string tag);
      clr();
      go(1'b0, 1'b0, 1'b0);
      check({tag, "_cnt0"}, {26'd0, iter_cnt}, 25);
      check({tag, "_inc0"}, {28'd0, incfunc}, 4'h8);
      run_to_idle(tag);
      check({tag, "_n8"}, n8, 26);
      check({tag, "_n9"}, n9, 1);
      check({tag, "_nb"}, nb, 1);
      check({tag, "_done"}, ndone, 1);
      check({tag, "_busy"}, nbusy, 28);
      check({tag, "_lead"}, lead_err, 0);
      check({tag, "_idle_inc"}, {28'd0, incfunc}, 4'h0);
   endtask

   initial begin
      checks = 0; errors = 0; clr();
      reset_l = 1'b0; fpuhold = 1'b0; start = 1'b0; dprec = 1'b0;
      rem_op = 1'b0; div0 = 1'b0; abort = 1'b0;
      #3;
      check("rst_inc", {28'd0, incfunc}, 4'h0);
      check("rst_nx", {28'd0, nx_incfunc}, 4'h0);
      check("rst_flags", {29'd0, busy, done, dz}, 0);
      check("rst_cnt", {26'd0, iter_cnt}, 0);
      #20 reset_l = 1'b1;
      @(posedge clk);
      #1;

      single_divide("sp");

      clr();
      go(1'b1, 1'b1, 1'b0);
      check("dp_cnt0", {26'd0, iter_cnt}, 54);
      run_to_idle("dp");
      check("dp_n8", n8, 55);
      check("dp_n9", n9, 0);
      check("dp_done", ndone, 1);
      check("dp_busy", nbusy, 56);
      check("dp_lead", lead_err, 0);

      clr();
      go(1'b0, 1'b0, 1'b1);
      check("dz_state", {28'd0, done, dz, busy, 1'b0}, 4'b1110);
      check("dz_inc", {28'd0, incfunc}, 4'hb);
      step();
      check("dz_after", {29'd0, done, dz, busy}, 0);
      check("dz_n8", n8, 0);

      clr();
      go(1'b0, 1'b0, 1'b0);
      wait_cnt("hold", 10);
      fpuhold = 1'b1;
      repeat (5) step();
      check("hold_cnt", {26'd0, iter_cnt}, 10);
      check("hold_inc", {28'd0, incfunc}, 4'h8);
      check("hold_nx", {28'd0, nx_incfunc}, 4'h8);
      fpuhold = 1'b0;
      run_to_idle("hold");
      check("hold_n8", n8, 31);
      check("hold_busy", nbusy, 33);
      check("hold_done", ndone, 1);
      check("hold_lead", lead_err, 0);

      clr();
      go(1'b0, 1'b0, 1'b0);
      wait_cnt("abt", 3);
      abort = 1'b1; fpuhold = 1'b1;
      step();
      abort = 1'b0; fpuhold = 1'b0;
      check("abt_state", {29'd0, busy, done, dz}, 0);
      check("abt_inc", {28'd0, incfunc}, 4'h0);
      check("abt_cnt", {26'd0, iter_cnt}, 0);
      check("abt_nodone", ndone, 0);
      go(1'b0, 1'b0, 1'b0);
      check("abt_restart", {31'd0, busy}, 1);
      check("abt_restart_cnt", {26'd0, iter_cnt}, 25);
      run_to_idle("abt2");

      abort = 1'b1; start = 1'b1;
      step();
      abort = 1'b0; start = 1'b0;
      check("abt_idle_start", {31'd0, busy}, 0);

      go(1'b0, 1'b0, 1'b0);
      wait_cnt("ar", 15);
      #2 reset_l = 1'b0;
      #1;
      check("ar_inc", {28'd0, incfunc}, 4'h0);
      check("ar_flags", {29'd0, busy, done, dz}, 0);
      check("ar_cnt", {26'd0, iter_cnt}, 0);
      @(negedge clk);
      reset_l = 1'b1;
      @(posedge clk);
      #1;
      single_divide("ar_sp");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
